// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register: captures decode controls, operands and register fields,
// and inserts a bubble on a taken-branch flush or a load-use hazard.
module id_ex_pipeline_register #(
   parameter int B = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush_in,
   input  logic         wb_RegWrite_in,
   input  logic         wb_MemtoReg_in,
   input  logic         m_Branch_in,
   input  logic         m_MemRead_in,
   input  logic         m_MemWrite_in,
   input  logic         ex_RegDst_in,
   input  logic         ex_ALUOp0_in,
   input  logic         ex_ALUOp1_in,
   input  logic         ex_ALUSrc_in,
   input  logic [B-1:0] pc_next_in,
   input  logic [B-1:0] reg_data1_in,
   input  logic [B-1:0] reg_data2_in,
   input  logic [B-1:0] sign_ext_in,
   input  logic [4:0]   rs_in,
   input  logic [4:0]   rt_in,
   input  logic [4:0]   rd_in,
   output logic         wb_RegWrite_out,
   output logic         wb_MemtoReg_out,
   output logic         m_Branch_out,
   output logic         m_MemRead_out,
   output logic         m_MemWrite_out,
   output logic         ex_RegDst_out,
   output logic         ex_ALUOp0_out,
   output logic         ex_ALUOp1_out,
   output logic         ex_ALUSrc_out,
   output logic [B-1:0] pc_next_out,
   output logic [B-1:0] reg_data1_out,
   output logic [B-1:0] reg_data2_out,
   output logic [B-1:0] sign_ext_out,
   output logic [4:0]   rs_out,
   output logic [4:0]   rt_out,
   output logic [4:0]   rd_out,
   output logic         valid_out,
   output logic         stall_out
);

   logic bubble;

   // A lw in EX whose destination (rt) is read by the ID instruction; $zero never hazards.
   assign stall_out = m_MemRead_out & valid_out & (rt_out != 5'd0) &
                      ((rt_out == rs_in) | (rt_out == rt_in));

   assign bubble = flush_in | stall_out;

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_RegWrite_out <= 1'b0;
         wb_MemtoReg_out <= 1'b0;
         m_Branch_out    <= 1'b0;
         m_MemRead_out   <= 1'b0;
         m_MemWrite_out  <= 1'b0;
         ex_RegDst_out   <= 1'b0;
         ex_ALUOp0_out   <= 1'b0;
         ex_ALUOp1_out   <= 1'b0;
         ex_ALUSrc_out   <= 1'b0;
         pc_next_out     <= '0;
         reg_data1_out   <= '0;
         reg_data2_out   <= '0;
         sign_ext_out    <= '0;
         rs_out          <= '0;
         rt_out          <= '0;
         rd_out          <= '0;
         valid_out       <= 1'b0;
      end else begin
         // Data and address fields are don't-care in a bubble, so they load ungated.
         pc_next_out     <= pc_next_in;
         reg_data1_out   <= reg_data1_in;
         reg_data2_out   <= reg_data2_in;
         sign_ext_out    <= sign_ext_in;
         rs_out          <= rs_in;
         rt_out          <= rt_in;
         rd_out          <= rd_in;
         if (bubble) begin
            wb_RegWrite_out <= 1'b0;
            wb_MemtoReg_out <= 1'b0;
            m_Branch_out    <= 1'b0;
            m_MemRead_out   <= 1'b0;
            m_MemWrite_out  <= 1'b0;
            ex_RegDst_out   <= 1'b0;
            ex_ALUOp0_out   <= 1'b0;
            ex_ALUOp1_out   <= 1'b0;
            ex_ALUSrc_out   <= 1'b0;
            valid_out       <= 1'b0;
         end else begin
            wb_RegWrite_out <= wb_RegWrite_in;
            wb_MemtoReg_out <= wb_MemtoReg_in;
            m_Branch_out    <= m_Branch_in;
            m_MemRead_out   <= m_MemRead_in;
            m_MemWrite_out  <= m_MemWrite_in;
            ex_RegDst_out   <= ex_RegDst_in;
            ex_ALUOp0_out   <= ex_ALUOp0_in;
            ex_ALUOp1_out   <= ex_ALUOp1_in;
            ex_ALUSrc_out   <= ex_ALUSrc_in;
            valid_out       <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Bench for id_ex_pipeline_register: directed hazard/flush/reset scenarios plus
// randomized traffic checked against a slot-level reference model.
module tb_id_ex_pipeline_register;
   localparam int B = 32;
   // Control vector order: RegWrite MemtoReg Branch MemRead MemWrite RegDst ALUOp0 ALUOp1 ALUSrc
   localparam logic [8:0] CTRL_R  = 9'b1_0000_1010;
   localparam logic [8:0] CTRL_LW = 9'b1_1010_0001;

   typedef struct packed {
      logic [8:0]   ctrl;
      logic [B-1:0] pc, d1, d2, se;
      logic [4:0]   rs, rt, rd;
      logic         valid;
   } slot_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, flush_in;
   logic [8:0]   ctrl_in;
   logic [B-1:0] pc_in, d1_in, d2_in, se_in;
   logic [4:0]   rs_in, rt_in, rd_in;

   logic wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_MemRead_out, m_MemWrite_out;
   logic ex_RegDst_out, ex_ALUOp0_out, ex_ALUOp1_out, ex_ALUSrc_out;
   logic [B-1:0] pc_next_out, reg_data1_out, reg_data2_out, sign_ext_out;
   logic [4:0]   rs_out, rt_out, rd_out;
   logic         valid_out, stall_out;
   logic [8:0]   ctrl_out;

   assign ctrl_out = {wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_MemRead_out,
                      m_MemWrite_out, ex_RegDst_out, ex_ALUOp0_out, ex_ALUOp1_out, ex_ALUSrc_out};

   id_ex_pipeline_register #(.B(B)) dut (
      .clk(clk), .reset(reset), .flush_in(flush_in),
      .wb_RegWrite_in(ctrl_in[8]), .wb_MemtoReg_in(ctrl_in[7]), .m_Branch_in(ctrl_in[6]),
      .m_MemRead_in(ctrl_in[5]), .m_MemWrite_in(ctrl_in[4]), .ex_RegDst_in(ctrl_in[3]),
      .ex_ALUOp0_in(ctrl_in[2]), .ex_ALUOp1_in(ctrl_in[1]), .ex_ALUSrc_in(ctrl_in[0]),
      .pc_next_in(pc_in), .reg_data1_in(d1_in), .reg_data2_in(d2_in), .sign_ext_in(se_in),
      .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
      .wb_RegWrite_out(wb_RegWrite_out), .wb_MemtoReg_out(wb_MemtoReg_out),
      .m_Branch_out(m_Branch_out), .m_MemRead_out(m_MemRead_out),
      .m_MemWrite_out(m_MemWrite_out), .ex_RegDst_out(ex_RegDst_out),
      .ex_ALUOp0_out(ex_ALUOp0_out), .ex_ALUOp1_out(ex_ALUOp1_out),
      .ex_ALUSrc_out(ex_ALUSrc_out), .pc_next_out(pc_next_out),
      .reg_data1_out(reg_data1_out), .reg_data2_out(reg_data2_out),
      .sign_ext_out(sign_ext_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
      .valid_out(valid_out), .stall_out(stall_out)
   );

   int vectors = 0;
   int miscompares = 0;
   slot_t model;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // The EX slot holds a real load whose destination the ID instruction reads.
   function automatic logic model_hazard();
      return model.valid && model.ctrl[5] && model.rt != 5'd0 &&
             (model.rt == rs_in || model.rt == rt_in);
   endfunction

   task automatic rand_data();
      pc_in = $urandom; d1_in = $urandom; d2_in = $urandom; se_in = $urandom;
      rd_in = 5'($urandom);
   endtask

   task automatic set_id(input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt);
      ctrl_in = c; rs_in = rs; rt_in = rt;
      rand_data();
   endtask

   // Check the hazard output, advance one edge, then compare the whole EX slot.
   task automatic cycle();
      slot_t nxt;
      logic  haz;
      #1;
      haz = model_hazard();
      check("stall", stall_out, haz);
      if (reset) nxt = '0;
      else begin
         nxt = '{ctrl: ctrl_in, pc: pc_in, d1: d1_in, d2: d2_in, se: se_in,
                 rs: rs_in, rt: rt_in, rd: rd_in, valid: 1'b1};
         if (flush_in || haz) begin
            nxt.ctrl  = '0;
            nxt.valid = 1'b0;
         end
      end
      @(posedge clk);
      model = nxt;
      #1;
      check("ctrl", ctrl_out, model.ctrl);
      check("valid", valid_out, model.valid);
      check("pc", pc_next_out, model.pc);
      check("data1", reg_data1_out, model.d1);
      check("data2", reg_data2_out, model.d2);
      check("sext", sign_ext_out, model.se);
      check("regs", {rs_out, rt_out, rd_out}, {model.rs, model.rt, model.rd});
   endtask

   initial begin
      reset = 1'b1; flush_in = 1'b0;
      set_id(9'($urandom), 5'($urandom), 5'($urandom));
      @(posedge clk);
      model = '0;
      // Reset held a second cycle with random inputs.
      set_id(9'($urandom), 5'($urandom), 5'($urandom));
      cycle();
      check("reset_stall", stall_out, 1'b0);
      reset = 1'b0;

      // R-type pass-through.
      set_id(CTRL_R, 5'd1, 5'd2);
      d1_in = 32'h0000_0005; rd_in = 5'd3;
      cycle();
      check("rtype_ctrl", ctrl_out, CTRL_R);
      check("rtype_data1", reg_data1_out, 32'h5);
      check("rtype_rd", rd_out, 5'd3);
      check("rtype_valid", valid_out, 1'b1);

      // Load-use: lw rt=8 in EX, ID reads rs=8.
      set_id(CTRL_LW, 5'd4, 5'd8);
      cycle();
      set_id(CTRL_R, 5'd8, 5'd12);
      #1 check("lu_stall_on", stall_out, 1'b1);
      cycle();
      check("lu_bubble_ctrl", ctrl_out, 9'd0);
      check("lu_bubble_valid", valid_out, 1'b0);
      check("lu_stall_off", stall_out, 1'b0);
      cycle();
      check("lu_capture", ctrl_out, CTRL_R);
      check("lu_capture_valid", valid_out, 1'b1);

      // No false stall: rt=0 and non-matching registers.
      set_id(CTRL_LW, 5'd1, 5'd0);
      cycle();
      set_id(CTRL_R, 5'd0, 5'd0);
      #1 check("nostall_zero", stall_out, 1'b0);
      cycle();
      set_id(CTRL_LW, 5'd1, 5'd8);
      cycle();
      set_id(CTRL_R, 5'd9, 5'd10);
      #1 check("nostall_diff", stall_out, 1'b0);
      cycle();

      // Flush with lw controls.
      flush_in = 1'b1;
      set_id(CTRL_LW, 5'd5, 5'd6);
      cycle();
      flush_in = 1'b0;
      check("flush_ctrl", ctrl_out, 9'd0);
      check("flush_valid", valid_out, 1'b0);

      // Flush and stall together, then reset while a stall is pending.
      set_id(CTRL_LW, 5'd1, 5'd8);
      cycle();
      flush_in = 1'b1;
      set_id(CTRL_R, 5'd8, 5'd3);
      #1 check("fs_stall", stall_out, 1'b1);
      cycle();
      flush_in = 1'b0;
      check("fs_bubble", {ctrl_out, valid_out}, 10'd0);
      set_id(CTRL_LW, 5'd2, 5'd7);
      cycle();
      reset = 1'b1;
      set_id(CTRL_R, 5'd7, 5'd7);
      #1 check("rst_mid_stall_on", stall_out, 1'b1);
      cycle();
      reset = 1'b0;
      check("rst_mid_clear", {ctrl_out, valid_out, rt_out, reg_data1_out}, '0);
      check("rst_mid_stall_off", stall_out, 1'b0);

      // Randomized traffic biased toward loads and a small register set.
      for (int i = 0; i < 500; i++) begin
         reset    = ($urandom_range(0, 49) == 0);
         flush_in = ($urandom_range(0, 9) == 0);
         set_id(9'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         if ($urandom_range(0, 1) == 1) ctrl_in[5] = 1'b1;
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
